// File: rtl/sys_mem_resp.sv
// rtl/sys_mem_resp.sv - fixed-latency 8K x 16 memory responder (IDLE/BUSY/RESP handshake)
// Optional access counters enabled by defining SYS_MEM_RESP_ACCESS_CNT_EN.
module sys_mem_resp #(
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        read_req,
   input  logic        write_req,
   input  logic [13:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        mem_resp,
   output logic        proto_err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [15:0] mem [0:8191];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_wr_q, op_wr_d;
   logic [12:0] idx_q, idx_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        mem_resp_q, mem_resp_d;
   logic        proto_err_q, proto_err_d;

   logic        req_held;
   logic        done;
   logic        done_wr;
   logic [12:0] done_idx;
   logic [15:0] done_wdata;
   logic        unused_addr0;

   assign unused_addr0 = addr[0];
   // Only the line that was accepted keeps the transaction alive.
   assign req_held = cs && (op_wr_q ? write_req : read_req);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_wr_d     = op_wr_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      mem_resp_d  = mem_resp_q;
      proto_err_d = proto_err_q;
      done        = 1'b0;
      done_wr     = op_wr_q;
      done_idx    = idx_q;
      done_wdata  = wdata_q;
      case (state_q)
         IDLE: begin
            mem_resp_d = 1'b0;
            if (cs && read_req && write_req) begin
               proto_err_d = 1'b1;
            end else if (cs && (read_req ^ write_req)) begin
               op_wr_d = write_req;
               idx_d   = addr[13:1];
               wdata_d = wdata;
               cnt_d   = LAT_M1;
               if (LATENCY == 1) begin
                  // Single-cycle latency completes on the acceptance edge itself.
                  state_d    = RESP;
                  done       = 1'b1;
                  done_wr    = write_req;
                  done_idx   = addr[13:1];
                  done_wdata = wdata;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (!req_held) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
               done    = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (!req_held) begin
               state_d    = IDLE;
               mem_resp_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         mem_resp_d = 1'b1;
         if (!done_wr) rdata_d = mem[done_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_wr_q     <= 1'b0;
         idx_q       <= 13'd0;
         wdata_q     <= 16'h0000;
         rdata_q     <= 16'h0000;
         mem_resp_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         mem_resp_q  <= mem_resp_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Storage has no reset; reset only suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (reset_n && done && done_wr) mem[done_idx] <= done_wdata;
   end

`ifdef SYS_MEM_RESP_ACCESS_CNT_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (done && !done_wr) rd_count_d = rd_count_q + 16'd1;
      if (done && done_wr)  wr_count_d = wr_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_count_q <= 16'h0000;
         wr_count_q <= 16'h0000;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   assign rd_count = 16'h0000;
   assign wr_count = 16'h0000;
`endif

   assign rdata     = rdata_q;
   assign mem_resp  = mem_resp_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sys_mem_resp.sv
// tb/tb_sys_mem_resp.sv - directed table-driven bench for sys_mem_resp
module tb_sys_mem_resp;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs;
   logic        read_req;
   logic        write_req;
   logic [13:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        mem_resp;
   logic        proto_err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   int n_cmp  = 0;
   int n_fail = 0;

   sys_mem_resp #(.LATENCY(LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cs        (cs),
      .read_req  (read_req),
      .write_req (write_req),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .mem_resp  (mem_resp),
      .proto_err (proto_err),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [13:0] a;
      logic [15:0] d;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef SYS_MEM_RESP_ACCESS_CNT_EN
      return n;
`else
      return 16'h0000 & n;
`endif
   endfunction

   // Full handshake: checks latency, rdata, hold behaviour and release.
   task automatic do_txn(input logic wr, input logic [13:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input string tag);
      int k;
      @(negedge clk);
      cs = 1'b1; read_req = !wr; write_req = wr; addr = a; wdata = d;
      @(posedge clk);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!mem_resp && k < 40);
      check({tag, " latency"}, k, LAT);
      check({tag, " rdata"}, {16'h0, rdata}, {16'h0, exp_rd});
      @(negedge clk);
      addr = ~a; wdata = ~d;
      write_req = !wr ? 1'b1 : write_req;
      repeat (2) @(posedge clk);
      #1;
      check({tag, " hold resp"}, {31'h0, mem_resp}, 32'd1);
      check({tag, " hold rdata"}, {16'h0, rdata}, {16'h0, exp_rd});
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b0;
      @(posedge clk); #1;
      check({tag, " release"}, {31'h0, mem_resp}, 32'd0);
   endtask

   initial begin
      int seen;
      vecs[0] = '{1'b1, 14'h0010, 16'hA55A, 16'h0000};
      vecs[1] = '{1'b0, 14'h0011, 16'h0000, 16'hA55A};
      vecs[2] = '{1'b1, 14'h0020, 16'hBEEF, 16'hA55A};
      vecs[3] = '{1'b1, 14'h3FFE, 16'h0F0F, 16'hA55A};
      vecs[4] = '{1'b0, 14'h3FFF, 16'h0000, 16'h0F0F};
      vecs[5] = '{1'b0, 14'h0021, 16'h0000, 16'hBEEF};
      vecs[6] = '{1'b1, 14'h0000, 16'h1111, 16'hBEEF};
      vecs[7] = '{1'b0, 14'h0001, 16'h0000, 16'h1111};

      reset_n = 1'b0; cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
      addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset mem_resp", {31'h0, mem_resp}, 32'd0);
      check("reset rdata", {16'h0, rdata}, 32'd0);
      check("reset proto_err", {31'h0, proto_err}, 32'd0);
      check("reset rd_count", {16'h0, rd_count}, 32'd0);
      check("reset wr_count", {16'h0, wr_count}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      #1;
      check("table rd_count", {16'h0, rd_count}, {16'h0, exp_cnt(16'd4)});
      check("table wr_count", {16'h0, wr_count}, {16'h0, exp_cnt(16'd4)});

      // cs low: request ignored
      @(negedge clk);
      cs = 1'b0; read_req = 1'b1; addr = 14'h0010;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (mem_resp) seen = 1;
      end
      check("cs low no resp", seen, 0);
      @(negedge clk);
      read_req = 1'b0;

      // both requests at once
      @(negedge clk);
      cs = 1'b1; read_req = 1'b1; write_req = 1'b1;
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (mem_resp) seen = 1;
      end
      check("proto no resp", seen, 0);
      check("proto_err set", {31'h0, proto_err}, 32'd1);

      // aborted write leaves memory untouched
      @(negedge clk);
      cs = 1'b1; write_req = 1'b1; addr = 14'h0020; wdata = 16'h1234;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      write_req = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (mem_resp) seen = 1;
      end
      check("abort no resp", seen, 0);
      do_txn(1'b0, 14'h0020, 16'h0000, 16'hBEEF, "post-abort read");
      check("proto_err sticky", {31'h0, proto_err}, 32'd1);
      check("abort wr_count", {16'h0, wr_count}, {16'h0, exp_cnt(16'd4)});

      // reset during read RESP
      @(negedge clk);
      cs = 1'b1; read_req = 1'b1; addr = 14'h0010;
      seen = 0;
      while (!mem_resp && seen < 40) begin
         @(posedge clk); #1;
         seen++;
      end
      check("pre-reset rdata", {16'h0, rdata}, 32'h0000A55A);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rst resp drop", {31'h0, mem_resp}, 32'd0);
      check("rst rdata", {16'h0, rdata}, 32'd0);
      check("rst proto_err", {31'h0, proto_err}, 32'd0);
      check("rst rd_count", {16'h0, rd_count}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1; read_req = 1'b0;

      // reset during BUSY discards a pending write
      @(negedge clk);
      cs = 1'b1; write_req = 1'b1; addr = 14'h0000; wdata = 16'h7777;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0; write_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      do_txn(1'b0, 14'h0001, 16'h0000, 16'h1111, "mem survives reset");
      do_txn(1'b1, 14'h0100, 16'h5A5A, 16'h1111, "w1");
      do_txn(1'b0, 14'h0100, 16'h0000, 16'h5A5A, "r2");
      do_txn(1'b1, 14'h0102, 16'hC3C3, 16'h5A5A, "w2");
      do_txn(1'b0, 14'h0103, 16'h0000, 16'hC3C3, "r3");
      #1;
      check("final rd_count", {16'h0, rd_count}, {16'h0, exp_cnt(16'd3)});
      check("final wr_count", {16'h0, wr_count}, {16'h0, exp_cnt(16'd2)});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
